ram_port_b_arbiter: RTL and testbench
=====================================

// Module: ram_port_b_arbiter
// PURPOSE
//  Shares dpram port B between two requesters: req0 = vga glyph/frame fetch (real-time,
//  read-only) and req1 = auxiliary master (sprite copier / debug loader, read+write).
//  Sits between the requesters and dpram en_B/addr_B/data_B/out_B.
//  Fixed priority to req0, with a starvation guard that forces a req1 grant.
//  Returns read data to the requester that issued the read.
// PARAMETERS
//  ADDR_WIDTH    16  port B address width
//  DATA_WIDTH    16  port B data width
//  READ_LATENCY  1   cycles from granted read to out_B valid (1..4)
//  STARVE_LIMIT  8   consecutive cycles req1 may be denied before a forced grant (2..255)
// PORTS
//  clk          in   1    system clock, all state on rising edge
//  reset        in   1    synchronous, active-high
//  req0         in   1    vga read request (held until gnt0)
//  addr0        in   ADDR_WIDTH  vga read address
//  gnt0         out  1    req0 accepted this cycle (combinational)
//  rvalid0      out  1    rdata valid for req0
//  req1         in   1    aux request (held until gnt1)
//  we1          in   1    aux access is a write
//  addr1        in   ADDR_WIDTH  aux address
//  wdata1       in   DATA_WIDTH  aux write data
//  gnt1         out  1    req1 accepted this cycle (combinational)
//  rvalid1      out  1    rdata valid for req1 (reads only)
//  rdata        out  DATA_WIDTH  shared read data = mem_q
//  mem_en       out  1    to dpram en_B (write enable)
//  mem_addr     out  ADDR_WIDTH  to dpram addr_B
//  mem_wdata    out  DATA_WIDTH  to dpram data_B
//  mem_q        in   DATA_WIDTH  from dpram out_B
// BEHAVIOUR
//  - One access per cycle. Grant decision is combinational from req0/req1/starve state.
//  - Mode NORMAL: req0 wins if asserted; else req1 wins if asserted.
//  - starve_cnt: +1 each cycle req1=1 && gnt1=0 (saturates at STARVE_LIMIT); cleared on gnt1.
//  - Mode FORCE when starve_cnt==STARVE_LIMIT: req1 granted even if req0=1; gnt0=0 that
//    cycle. Next cycle starve_cnt=0, back to NORMAL. Forced grant never two cycles in a row.
//  - Simultaneous req0/req1 with starve_cnt<LIMIT: gnt0=1, gnt1=0, counter increments.
//  - Mux: granted requester drives mem_addr; mem_en = gnt1 & we1; mem_wdata = wdata1.
//    No grant: mem_addr=0, mem_en=0, mem_wdata=0.
//  - Read return: tag pipe of READ_LATENCY stages, each {valid,id}; stage0 loads
//    {1,0} on gnt0, {1,1} on gnt1&~we1, {0,x} otherwise. At pipe output: rvalid0 =
//    valid&id==0, rvalid1 = valid&id==1. Writes never produce rvalid. Back-to-back
//    reads return back-to-back in grant order.
//  - rdata is mem_q passthrough; meaningful only when rvalid0|rvalid1.
//  - Reset (any cycle, incl. mid-read): gnt0=gnt1=0 and mem_en=0 while reset=1;
//    starve_cnt=0; tag pipe cleared -> in-flight reads dropped, no rvalid after reset.
//    All outputs 0 in the first cycle after reset deasserts unless a request is present.
//  - req deasserted without grant: permitted; starve_cnt clears when req1=0.
// TESTING
//  1 req0 only, addr0=0x0040 for 4 cycles -> gnt0=1 each cycle, rvalid0 at +1 each,
//    rdata = RAM[0x40]; rvalid1 never asserts.
//  2 req1 write we1=1 addr1=0x0100 wdata1=0xBEEF, then read 0x0100 -> mem_en=1 one cycle,
//    no rvalid for write; read returns rvalid1 with rdata=0xBEEF.
//  3 req0 and req1(read) held high continuously, STARVE_LIMIT=8 -> gnt0 for 8 cycles,
//    gnt1 on 9th (gnt0=0), repeating 8:1; each rvalid tagged to correct requester.
//  4 READ_LATENCY=3, alternating reads req0/req1 -> rvalid0/rvalid1 alternate 3 cycles
//    after each grant, data matches preloaded RAM.
//  5 reset asserted one cycle after a granted req1 read -> no rvalid1 ever, starve_cnt=0,
//    mem_en=0 during reset even with req1&we1 high.
//  6 req1 idle-toggled (1 cycle high under req0 contention, then low) -> starve_cnt
//    returns to 0, no forced grant issued.

Source files
------------

// File: rtl/ram_port_b_arbiter.sv
// ram_port_b_arbiter: shares dpram port B between a real-time vga reader and an aux read/write master,
// fixed priority to vga with a starvation-forced aux grant and a tag pipe routing read data back.
module ram_port_b_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   output logic                  gnt0,
   output logic                  rvalid0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_q
);
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic [7:0]              starve_q, starve_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d, id_q, id_d;
   logic                    force_grant;
   assign force_grant = req1 && starve_q == LIMIT;
   always_comb begin
      gnt0      = !reset && req0 && !force_grant;
      gnt1      = !reset && req1 && (force_grant || !req0);
      mem_en    = gnt1 && we1;
      mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
      mem_wdata = gnt1 ? wdata1 : '0;
      starve_d  = (gnt1 || !req1) ? 8'd0 : (starve_q == LIMIT) ? starve_q : starve_q + 8'd1;
      // shift a new {valid,id} tag in at stage 0; the top bit is the pipe output
      vld_d     = READ_LATENCY'({vld_q, gnt0 || (gnt1 && !we1)});
      id_d      = READ_LATENCY'({id_q, gnt1});
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= '0;
         vld_q    <= '0;
         id_q     <= '0;
      end else begin
         starve_q <= starve_d;
         vld_q    <= vld_d;
         id_q     <= id_d;
      end
   end
   assign rvalid0 = !reset && vld_q[READ_LATENCY-1] && !id_q[READ_LATENCY-1];
   assign rvalid1 = !reset && vld_q[READ_LATENCY-1] && id_q[READ_LATENCY-1];
   assign rdata   = mem_q;
endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// tb_ram_port_b_arbiter: drives one stimulus into two arbiters (read latency 1 and 3) backed by
// behavioural dprams; a grant model plus a read-return scoreboard checks every cycle.
module tb_ram_port_b_arbiter;
   localparam int LIMIT = 8;
   logic        clk = 0, reset = 1;
   logic        req0 = 0, req1 = 0, we1 = 0;
   logic [15:0] addr0 = 0, addr1 = 0, wdata1 = 0;
   logic        gnt0_a, gnt1_a, rv0_a, rv1_a, en_a;
   logic        gnt0_b, gnt1_b, rv0_b, rv1_b, en_b;
   logic [15:0] rdata_a, maddr_a, mwd_a, mq_a;
   logic [15:0] rdata_b, maddr_b, mwd_b, mq_b;
   logic [15:0] ram_a [0:65535];
   logic [15:0] ram_b [0:65535];
   logic [15:0] gold  [0:65535];
   logic [15:0] pb1, pb2, pb3;
   typedef struct { int due; bit id; logic [15:0] data; } ret_t;
   ret_t qa[$], qb[$];
   int n_chk = 0, n_fail = 0, cyc = 0, starve_m = 0;

   always #5 clk = ~clk;

   ram_port_b_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut_a (
      .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rv0_a),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_a), .rvalid1(rv1_a),
      .rdata(rdata_a), .mem_en(en_a), .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_q(mq_a));

   ram_port_b_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(LIMIT)) dut_b (
      .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rv0_b),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1_b), .rvalid1(rv1_b),
      .rdata(rdata_b), .mem_en(en_b), .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_q(mq_b));

   always @(posedge clk) begin
      if (en_a) ram_a[maddr_a] <= mwd_a;
      if (en_b) ram_b[maddr_b] <= mwd_b;
      mq_a <= ram_a[maddr_a];
      pb1  <= ram_b[maddr_b];
      pb2  <= pb1;
      pb3  <= pb2;
   end
   assign mq_b = pb3;

   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      logic  frc, g0, g1, e0, e1;
      logic [15:0] ea, ed;
      ret_t t;
      frc = req1 && starve_m == LIMIT;
      g0  = !reset && req0 && !frc;
      g1  = !reset && req1 && (frc || !req0);
      ea  = g0 ? addr0 : g1 ? addr1 : 16'h0;
      chk("grant_a", {gnt0_a, gnt1_a, en_a, maddr_a}, {g0, g1, g1 && we1, ea});
      chk("grant_b", {gnt0_b, gnt1_b, en_b, maddr_b}, {g0, g1, g1 && we1, ea});
      if (!g0) chk("wdata_a", mwd_a, g1 ? wdata1 : 16'h0);
      if (reset) begin
         qa.delete();
         qb.delete();
      end
      e0 = 0; e1 = 0; ed = 0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
         t = qa.pop_front(); e0 = !t.id; e1 = t.id; ed = t.data;
      end
      chk("rvalid_a", {rv0_a, rv1_a}, {e0, e1});
      if (e0 || e1) chk("rdata_a", rdata_a, ed);
      e0 = 0; e1 = 0; ed = 0;
      if (qb.size() > 0 && qb[0].due == cyc) begin
         t = qb.pop_front(); e0 = !t.id; e1 = t.id; ed = t.data;
      end
      chk("rvalid_b", {rv0_b, rv1_b}, {e0, e1});
      if (e0 || e1) chk("rdata_b", rdata_b, ed);
      if (g0) begin
         qa.push_back('{cyc + 1, 1'b0, gold[addr0]});
         qb.push_back('{cyc + 3, 1'b0, gold[addr0]});
      end
      if (g1 && !we1) begin
         qa.push_back('{cyc + 1, 1'b1, gold[addr1]});
         qb.push_back('{cyc + 3, 1'b1, gold[addr1]});
      end
      if (g1 && we1) gold[addr1] = wdata1;
      starve_m = (reset || g1 || !req1) ? 0 : (starve_m < LIMIT ? starve_m + 1 : LIMIT);
      cyc++;
   end

   task automatic drive(input logic r0, input logic [15:0] a0, input logic r1, input logic w1,
                        input logic [15:0] a1, input logic [15:0] wd);
      req0 = r0; addr0 = a0; req1 = r1; we1 = w1; addr1 = a1; wdata1 = wd;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         gold[i]  = 16'(i * 3) ^ 16'h5A5A;
         ram_a[i] = gold[i];
         ram_b[i] = gold[i];
      end
      repeat (3) @(posedge clk);
      #1 reset = 0;
      idle(2);
      for (int i = 0; i < 4; i++) drive(1, 16'h0040, 0, 0, 16'h0, 16'h0);
      idle(4);
      drive(0, 16'h0, 1, 1, 16'h0100, 16'hBEEF);
      drive(0, 16'h0, 1, 0, 16'h0100, 16'h0);
      idle(4);
      for (int i = 0; i < 30; i++) drive(1, 16'(16'h0040 + i), 1, 0, 16'h0200, 16'h0);
      idle(4);
      for (int i = 0; i < 8; i++)
         if (i % 2 == 0) drive(1, 16'(16'h0300 + i), 0, 0, 16'h0, 16'h0);
         else            drive(0, 16'h0, 1, 0, 16'(16'h0400 + i), 16'h0);
      idle(4);
      for (int i = 0; i < 5; i++) drive(1, 16'h0050, 1, 0, 16'h0700, 16'h0);
      drive(0, 16'h0, 1, 0, 16'h0500, 16'h0);
      reset = 1;
      drive(0, 16'h0, 1, 1, 16'h0600, 16'h1234);
      drive(0, 16'h0, 1, 1, 16'h0600, 16'h1234);
      reset = 0;
      idle(5);
      for (int i = 0; i < 10; i++) drive(1, 16'h0060, 1, 0, 16'h0600, 16'h0);
      idle(2);
      for (int k = 0; k < 6; k++) begin
         drive(1, 16'h0070, 1, 0, 16'h0710, 16'h0);
         for (int i = 0; i < 3; i++) drive(1, 16'h0070, 0, 0, 16'h0, 16'h0);
      end
      for (int i = 0; i < 12; i++) drive(1, 16'h0080, 1, 1, 16'(16'h0800 + i), 16'(16'hC000 + i));
      drive(0, 16'h0, 1, 0, 16'h0800, 16'h0);
      idle(6);
      chk("drain_a", 36'(qa.size()), 36'd0);
      chk("drain_b", 36'(qb.size()), 36'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
